switch_word_loader: RTL and testbench
=====================================

Name: switch_word_loader

Overview:
- Input-side counterpart of the board's hex register-view path: takes operator data from the DE2 switches and pushbuttons and delivers it into the processor.
- Assembles a 32-bit word from two 16-bit switch entries, low half first, then high half.
- Offers the completed word on a valid/ready handshake that feeds the processor's ExternalData port.
- Exposes the staged word and entry status for the hex and LED display logic.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable clock cycles before a button level is accepted (5 ms at 50 MHz).
- CNT_W, 18, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- switch  input  16  data entry switches (switch[15:0] at top level)
- load_n  input  1  raw load button, active low (pushBut[2])
- cancel_n  input  1  raw cancel button, active low (pushBut[1])
- data_out  output  32  assembled word to processor
- data_valid  output  1  data_out holds a complete word
- data_ready  input  1  processor accepts data_out this cycle
- staged_word  output  32  current or last assembled word, for the hex display
- need_high  output  1  low half captured, waiting for high half
- busy  output  1  word offered and not yet accepted

Behaviour:
- Reset (async, active-high): state LOAD_LO; data_out, staged_word = 0; data_valid, need_high, busy = 0. Debouncer stable levels = 1 (released), counters = 0, sync FFs = 1.
- Debounce, per button:
  - Raw input passes a 2-FF synchronizer, producing s.
  - If s equals the stable level, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 with s still differing, stable <= s and the counter clears.
  - A one-cycle press pulse is asserted on the edge where stable goes 1->0. Release (0->1) generates no pulse.
  - Glitches shorter than DEBOUNCE_CYCLES never change stable.
- FSM states: LOAD_LO, LOAD_HI, SEND.
  - LOAD_LO + load pulse: staged_word[15:0] <= switch, staged_word[31:16] <= 0, go to LOAD_HI, need_high = 1.
  - LOAD_HI + load pulse: staged_word[31:16] <= switch, data_out <= {switch, staged_word[15:0]}, data_valid <= 1, go to SEND. need_high = 0, busy = 1.
  - LOAD_HI + cancel pulse: staged_word <= 0, go to LOAD_LO, need_high = 0.
  - LOAD_LO + cancel pulse: staged_word <= 0, stay in LOAD_LO.
  - SEND: data_out and data_valid are held stable until the edge where data_valid && data_ready. On that edge, data_valid <= 0, busy <= 0, go to LOAD_LO. staged_word keeps the sent word for display.
- Boundary conditions:
  - Load and cancel pulses in the same cycle: cancel wins and load is dropped.
  - Load or cancel pulse while in SEND: ignored. A committed word cannot be withdrawn.
  - data_ready high outside SEND: no effect.
  - data_ready already high when data_valid rises: transfer completes on the next edge, so valid is high for exactly 1 cycle.
  - Switch changes between presses: only the value sampled on the pulse edge is used. Switches are not synchronized; the operator holds them static.
  - Reset mid-entry or mid-SEND: immediate return to the reset values. Any partial or offered word is lost.
- Latency: raw press edge to state update = 2 sync cycles + DEBOUNCE_CYCLES + 1 edge.

Decomposition:
- Shared package holds:
  - state enum {LOAD_LO, LOAD_HI, SEND}
  - DEBOUNCE_DEFAULT constant
  - HALF_W = 16 and WORD_W = 32 constants
- One natural sub-module: button_debouncer (parameters DEBOUNCE_CYCLES and CNT_W; ports clk, reset, btn_n, stable, press_pulse), instantiated twice.

Test Plan (all scenarios use DEBOUNCE_CYCLES=4):
1. Reset, then switch=16'h1234 + load press, switch=16'hABCD + load press, data_ready=1 -> data_out=32'hABCD1234 and data_valid high for 1 cycle; staged_word stays 32'hABCD1234 afterwards; state returns to LOAD_LO.
2. load_n glitches low for 3 cycles -> no pulse, staged_word and state unchanged. Hold low for 10 cycles -> exactly one capture, at the predicted latency.
3. Low half 16'h00FF entered, then cancel press -> staged_word=0, need_high=0. Next load of 16'h5555 lands in the low half.
4. Word 32'h0000_0001 offered with data_ready=0 for 20 cycles while load and cancel are pressed -> data_out, data_valid and staged_word stable throughout. Raise data_ready -> single transfer.
5. Load and cancel stable transitions forced in the same cycle while in LOAD_HI -> cancel taken: staged_word=0, state LOAD_LO.
6. Reset asserted asynchronously mid-SEND (between clock edges) -> data_valid=0, data_out=0, busy=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/switch_word_loader_pkg.sv
// Shared types and constants for the switch word loader.
package switch_word_loader_pkg;

  // Button-level acceptance time: 5 ms at 50 MHz.
  localparam int DEBOUNCE_DEFAULT = 250000;

  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  // Entry sequence: low half, high half, then offer the word.
  typedef enum logic [1:0] {
    LOAD_LO = 2'd0,
    LOAD_HI = 2'd1,
    SEND    = 2'd2
  } state_t;

endpackage

// File: rtl/switch_word_loader_debouncer.sv
// Debouncer for one active-low pushbutton: 2-FF synchronizer, stability
// counter, and a one-cycle pulse when the accepted level goes 1->0.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic stable,
  output logic press_pulse
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // The candidate level has differed from the accepted level for long enough.
  assign accept = (sync2 != stable) && (cnt == LAST);

  // Bring the raw button into the clock domain.
  // NOTE: synchronizers reset to 1 (released) so leaving reset never looks like a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so sync2 takes sync1's old value, forming two real flops.
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  // Count consecutive cycles the synchronized level differs from the accepted one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      stable      <= 1'b1;
      press_pulse <= 1'b0;
    end else begin
      press_pulse <= accept && !sync2;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/switch_word_loader.sv
// Assembles a 32-bit word from two 16-bit switch entries (low half first)
// and offers it to the processor on a valid/ready handshake.
module switch_word_loader
  import switch_word_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [HALF_W-1:0] switch,
  input  logic              load_n,
  input  logic              cancel_n,
  output logic [WORD_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic [WORD_W-1:0] staged_word,
  output logic              need_high,
  output logic              busy
);

  state_t            state, state_d;
  logic [WORD_W-1:0] staged_d;
  logic [WORD_W-1:0] data_out_d;
  logic              load_pulse;
  logic              cancel_pulse;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_load_db (
    .clk        (clk),
    .reset      (reset),
    .btn_n      (load_n),
    .stable     (),
    .press_pulse(load_pulse)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_cancel_db (
    .clk        (clk),
    .reset      (reset),
    .btn_n      (cancel_n),
    .stable     (),
    .press_pulse(cancel_pulse)
  );

  // State and word registers; reset discards any partial or offered word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= LOAD_LO;
      staged_word <= '0;
      data_out    <= '0;
    end else begin
      state       <= state_d;
      staged_word <= staged_d;
      data_out    <= data_out_d;
    end
  end

  // Next-state and word updates; cancel outranks load, and SEND ignores both.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_d    = state;
    staged_d   = staged_word;
    data_out_d = data_out;
    unique case (state)
      LOAD_LO: begin
        if (cancel_pulse) begin
          staged_d = '0;
        end else if (load_pulse) begin
          staged_d = {{HALF_W{1'b0}}, switch};
          state_d  = LOAD_HI;
        end
      end
      LOAD_HI: begin
        if (cancel_pulse) begin
          staged_d = '0;
          state_d  = LOAD_LO;
        end else if (load_pulse) begin
          staged_d   = {switch, staged_word[HALF_W-1:0]};
          data_out_d = {switch, staged_word[HALF_W-1:0]};
          state_d    = SEND;
        end
      end
      SEND: begin
        if (data_ready) state_d = LOAD_LO;
      end
      default: state_d = LOAD_LO;
    endcase
  end

  assign data_valid = (state == SEND);
  assign busy       = (state == SEND);
  assign need_high  = (state == LOAD_HI);

endmodule

// File: tb/tb_switch_word_loader.sv
// Directed bench for switch_word_loader with a 4-cycle debounce window.
module tb_switch_word_loader;

  logic        clk;
  logic        reset;
  logic [15:0] switch;
  logic        load_n;
  logic        cancel_n;
  logic [31:0] data_out;
  logic        data_valid;
  logic        data_ready;
  logic [31:0] staged_word;
  logic        need_high;
  logic        busy;

  int checks = 0;
  int errors = 0;

  switch_word_loader #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .switch     (switch),
    .load_n     (load_n),
    .cancel_n   (cancel_n),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .staged_word(staged_word),
    .need_high  (need_high),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold the chosen buttons low 10 cycles, then released 10 cycles.
  // Press effect lands 7 edges after the drop; release settles within 7.
  task automatic press(input bit ld, input bit cn);
    if (ld) load_n = 1'b0;
    if (cn) cancel_n = 1'b0;
    wait_neg(10);
    load_n   = 1'b1;
    cancel_n = 1'b1;
    wait_neg(10);
  endtask

  initial begin
    reset      = 1'b1;
    switch     = 16'h0000;
    load_n     = 1'b1;
    cancel_n   = 1'b1;
    data_ready = 1'b0;
    wait_neg(2);
    check("rst_data_out", data_out, 32'h0);
    check("rst_valid", {31'b0, data_valid}, 32'h0);
    check("rst_staged", staged_word, 32'h0);
    check("rst_need_high", {31'b0, need_high}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    reset = 1'b0;
    wait_neg(2);

    // 1: basic word; data_ready high outside SEND has no effect.
    data_ready = 1'b1;
    switch     = 16'h1234;
    press(1'b1, 1'b0);
    check("t1_lo_staged", staged_word, 32'h0000_1234);
    check("t1_lo_need_high", {31'b0, need_high}, 32'h1);
    check("t1_lo_busy", {31'b0, busy}, 32'h0);
    switch = 16'hABCD;
    load_n = 1'b0;
    wait_neg(6);
    check("t1_hi_not_yet", {31'b0, data_valid}, 32'h0);
    wait_neg(1);
    check("t1_valid", {31'b0, data_valid}, 32'h1);
    check("t1_data_out", data_out, 32'hABCD_1234);
    check("t1_busy", {31'b0, busy}, 32'h1);
    check("t1_need_high_clr", {31'b0, need_high}, 32'h0);
    wait_neg(1);
    check("t1_valid_one_cycle", {31'b0, data_valid}, 32'h0);
    check("t1_busy_clr", {31'b0, busy}, 32'h0);
    check("t1_staged_kept", staged_word, 32'hABCD_1234);
    wait_neg(2);
    load_n = 1'b1;
    switch = 16'h0000;
    wait_neg(10);
    check("t1_idle_lo", {30'b0, need_high, busy}, 32'h0);
    check("t1_staged_after_sw", staged_word, 32'hABCD_1234);
    data_ready = 1'b0;

    // 2: 3-cycle glitch is rejected; a 10-cycle hold captures at edge 7.
    load_n = 1'b0;
    wait_neg(3);
    load_n = 1'b1;
    wait_neg(10);
    check("t2_glitch_staged", staged_word, 32'hABCD_1234);
    check("t2_glitch_state", {30'b0, need_high, busy}, 32'h0);
    switch = 16'h0042;
    load_n = 1'b0;
    wait_neg(6);
    check("t2_before_latency", {31'b0, need_high}, 32'h0);
    check("t2_before_staged", staged_word, 32'hABCD_1234);
    wait_neg(1);
    check("t2_at_latency", {31'b0, need_high}, 32'h1);
    check("t2_at_staged", staged_word, 32'h0000_0042);
    wait_neg(3);
    load_n = 1'b1;
    wait_neg(10);
    check("t2_release_no_pulse", {31'b0, need_high}, 32'h1);
    check("t2_release_staged", staged_word, 32'h0000_0042);
    press(1'b0, 1'b1);
    check("t2_cancel_staged", staged_word, 32'h0);

    // 3: cancel in LOAD_HI, then the next load lands in the low half.
    switch = 16'h00FF;
    press(1'b1, 1'b0);
    check("t3_lo_staged", staged_word, 32'h0000_00FF);
    press(1'b0, 1'b1);
    check("t3_cancel_staged", staged_word, 32'h0);
    check("t3_cancel_need_high", {31'b0, need_high}, 32'h0);
    switch = 16'h5555;
    press(1'b1, 1'b0);
    check("t3_reload_staged", staged_word, 32'h0000_5555);
    check("t3_reload_need_high", {31'b0, need_high}, 32'h1);
    press(1'b0, 1'b1);
    check("t3_cancel_lo_staged", staged_word, 32'h0);

    // 4: offered word is frozen while buttons are pressed in SEND.
    switch = 16'h0001;
    press(1'b1, 1'b0);
    switch = 16'h0000;
    press(1'b1, 1'b0);
    check("t4_offered_valid", {31'b0, data_valid}, 32'h1);
    check("t4_offered_data", data_out, 32'h0000_0001);
    switch   = 16'hFFFF;
    load_n   = 1'b0;
    cancel_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin
        load_n   = 1'b1;
        cancel_n = 1'b1;
      end
      wait_neg(1);
      check("t4_hold_data", data_out, 32'h0000_0001);
      check("t4_hold_valid", {31'b0, data_valid}, 32'h1);
      check("t4_hold_staged", staged_word, 32'h0000_0001);
    end
    data_ready = 1'b1;
    wait_neg(1);
    check("t4_xfer_valid", {31'b0, data_valid}, 32'h0);
    check("t4_xfer_busy", {31'b0, busy}, 32'h0);
    check("t4_xfer_staged", staged_word, 32'h0000_0001);
    data_ready = 1'b0;
    wait_neg(2);

    // 5: simultaneous load and cancel in LOAD_HI: cancel wins.
    switch = 16'h7777;
    press(1'b1, 1'b0);
    check("t5_lo_staged", staged_word, 32'h0000_7777);
    switch = 16'h8888;
    press(1'b1, 1'b1);
    check("t5_both_staged", staged_word, 32'h0);
    check("t5_both_state", {30'b0, need_high, busy}, 32'h0);
    check("t5_both_valid", {31'b0, data_valid}, 32'h0);

    // 6: asynchronous reset mid-SEND clears outputs between edges.
    switch = 16'h1111;
    press(1'b1, 1'b0);
    switch = 16'h2222;
    press(1'b1, 1'b0);
    check("t6_offered_data", data_out, 32'h2222_1111);
    check("t6_offered_valid", {31'b0, data_valid}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_valid", {31'b0, data_valid}, 32'h0);
    check("t6_async_data", data_out, 32'h0);
    check("t6_async_busy", {31'b0, busy}, 32'h0);
    check("t6_async_staged", staged_word, 32'h0);
    wait_neg(1);
    reset = 1'b0;
    wait_neg(2);
    check("t6_after_state", {30'b0, need_high, busy}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
